// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state type and compare codes for alu_seq
//
// Purpose: single source for the ALU opcode map, the sequencer state enum and
// the values written to the result bus by the compare operations.
// Ports: none (package).

package alu_pkg;

   // Arithmetic class
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_MUL    = 4'b0010;
   localparam logic [3:0] ALU_DIV    = 4'b0011;
   // Logic class
   localparam logic [3:0] ALU_AND    = 4'b0100;
   localparam logic [3:0] ALU_OR     = 4'b0101;
   localparam logic [3:0] ALU_NAND   = 4'b0110;
   localparam logic [3:0] ALU_NOR    = 4'b0111;
   localparam logic [3:0] ALU_XOR    = 4'b1000;
   localparam logic [3:0] ALU_XNOR   = 4'b1001;
   // Compare class
   localparam logic [3:0] ALU_CMP_EQ = 4'b1010;
   localparam logic [3:0] ALU_CMP_GT = 4'b1011;
   localparam logic [3:0] ALU_CMP_LT = 4'b1100;
   // Shift class
   localparam logic [3:0] ALU_SRL    = 4'b1101;
   localparam logic [3:0] ALU_SLL    = 4'b1110;
   // No operation: result 0, no flags
   localparam logic [3:0] ALU_NOP    = 4'b1111;

   // Values placed on the result bus when a compare holds (0 otherwise)
   localparam int CMP_EQ_RES = 1;
   localparam int CMP_GT_RES = 2;
   localparam int CMP_LT_RES = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DIV  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring divider, one quotient bit per clock
//
// Purpose: unsigned WIDTH/WIDTH division. The first step is taken on the start
// edge itself, the remaining WIDTH-1 on the following edges; o_done is high for
// one cycle once all WIDTH quotient bits are in o_quotient.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (aborts)
//   i_start               begin a division (ignored while busy)
//   i_dividend, i_divisor operands sampled on the start edge (divisor != 0)
//   o_busy                division in progress
//   o_done                quotient valid this cycle
//   o_quotient            quotient register

module alu_divider #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient
);

   localparam int CW = $clog2(WIDTH);

   logic           r_busy;
   logic [CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;

   logic [WIDTH-1:0] w_rem_in;
   logic [WIDTH-1:0] w_q_in;
   logic [WIDTH-1:0] w_div_in;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_q_next;

   // On the start edge the step operates on the fresh operands so that the
   // quotient is complete one edge earlier than a load-then-iterate scheme.
   assign w_rem_in = r_busy ? r_rem  : '0;
   assign w_q_in   = r_busy ? r_quot : i_dividend;
   assign w_div_in = r_busy ? r_div  : i_divisor;

   // Remainder is always below the divisor, so after the shift it needs one
   // extra bit; the trial subtraction's top bit is the borrow.
   assign w_shift    = {w_rem_in, w_q_in[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, w_div_in};
   assign w_fits     = ~w_trial[WIDTH];
   assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_q_next   = {w_q_in[WIDTH-2:0], w_fits};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_div  <= '0;
      end else if (r_busy) begin
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_quot <= w_q_next;
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt - 1'b1;
         end
      end else if (i_start) begin
         r_quot <= w_q_next;
         r_rem  <= w_rem_next;
         r_div  <= i_divisor;
         r_cnt  <= CW'(WIDTH - 1);
         r_busy <= 1'b1;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_cnt == '0);
   assign o_quotient = r_quot;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result, flags and iterative divide
//
// Purpose: accepts one operation per IN_VALID/IN_READY transfer. Single-cycle
// ops and divide-by-zero register their result on the transfer edge; a real
// divide runs alu_divider for WIDTH steps while IN_READY is low.
// Optional macro: ALU_BARREL_SHIFT_EN - shifts move A by B[$clog2(WIDTH)-1:0]
// positions instead of exactly one.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IN_VALID, IN_READY       operation handshake
//   A, B, ALU_FUN            unsigned operands, opcode
//   OUT_VALID                one-cycle pulse: result/flags updated
//   ALU_OUT                  result, held between OUT_VALID pulses
//   Arith/Logic/CMP/Shift_flag  class of last result (one-hot or zero)
//   Carry_flag               add carry-out / subtract borrow
//   Div_err                  last result was a divide by zero

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic             Arith_flag,
   output logic             Logic_flag,
   output logic             CMP_flag,
   output logic             Shift_flag,
   output logic             Carry_flag,
   output logic             Div_err
);

   alu_state_t r_state;
   alu_state_t w_next_state;

   logic             w_accept;
   logic             w_div_start;
   logic             w_load_single;
   logic             w_load_div;
   logic             w_div_busy;
   logic             w_div_done;
   logic [WIDTH-1:0] w_quotient;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_mul;
   logic [WIDTH-1:0] w_srl;
   logic [WIDTH-1:0] w_sll;

   logic [WIDTH-1:0] w_res;
   logic             w_arith, w_logic, w_cmp, w_shift, w_carry, w_err;

   assign w_accept    = IN_VALID && IN_READY;
   assign w_div_start = w_accept && (ALU_FUN == ALU_DIV) && (B != '0) && !w_div_busy;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_div_start) w_next_state = ST_DIV;
         ST_DIV:  if (w_div_done)  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      IN_READY      = (r_state == ST_IDLE);
      w_load_single = w_accept && !w_div_start;
      w_load_div    = (r_state == ST_DIV) && w_div_done;
   end

   alu_divider #(.WIDTH(WIDTH)) u_div (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_start    (w_div_start),
      .i_dividend (A),
      .i_divisor  (B),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_quotient)
   );

   // ---------------- single-cycle datapath ----------------
   assign w_sum  = {1'b0, A} + {1'b0, B};
   assign w_diff = {1'b0, A} - {1'b0, B};   // top bit set means A < B
   assign w_mul  = A * B;

`ifdef ALU_BARREL_SHIFT_EN
   localparam int SHW = $clog2(WIDTH);
   logic [SHW-1:0] w_shamt;
   assign w_shamt = B[SHW-1:0];
   assign w_srl   = A >> w_shamt;
   assign w_sll   = A << w_shamt;
`else
   assign w_srl   = A >> 1;
   assign w_sll   = A << 1;
`endif

   always_comb begin
      w_res   = '0;
      w_arith = 1'b0;
      w_logic = 1'b0;
      w_cmp   = 1'b0;
      w_shift = 1'b0;
      w_carry = 1'b0;
      w_err   = 1'b0;
      case (ALU_FUN)
         ALU_ADD:    begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  w_arith = 1'b1; end
         ALU_SUB:    begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; w_arith = 1'b1; end
         ALU_MUL:    begin w_res = w_mul; w_arith = 1'b1; end
         // Only reaches the result register when B is zero
         ALU_DIV:    begin w_res = '1; w_arith = 1'b1; w_err = 1'b1; end
         ALU_AND:    begin w_res = A & B;    w_logic = 1'b1; end
         ALU_OR:     begin w_res = A | B;    w_logic = 1'b1; end
         ALU_NAND:   begin w_res = ~(A & B); w_logic = 1'b1; end
         ALU_NOR:    begin w_res = ~(A | B); w_logic = 1'b1; end
         ALU_XOR:    begin w_res = A ^ B;    w_logic = 1'b1; end
         ALU_XNOR:   begin w_res = ~(A ^ B); w_logic = 1'b1; end
         ALU_CMP_EQ: begin w_res = (A == B) ? WIDTH'(CMP_EQ_RES) : '0; w_cmp = 1'b1; end
         ALU_CMP_GT: begin w_res = (A > B)  ? WIDTH'(CMP_GT_RES) : '0; w_cmp = 1'b1; end
         ALU_CMP_LT: begin w_res = (A < B)  ? WIDTH'(CMP_LT_RES) : '0; w_cmp = 1'b1; end
         ALU_SRL:    begin w_res = w_srl; w_shift = 1'b1; end
         ALU_SLL:    begin w_res = w_sll; w_shift = 1'b1; end
         default:    ;   // ALU_NOP: zero result, no flags
      endcase
   end

   // ---------------- result register ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID  <= 1'b0;
         ALU_OUT    <= '0;
         Arith_flag <= 1'b0;
         Logic_flag <= 1'b0;
         CMP_flag   <= 1'b0;
         Shift_flag <= 1'b0;
         Carry_flag <= 1'b0;
         Div_err    <= 1'b0;
      end else begin
         OUT_VALID <= 1'b0;
         if (w_load_single) begin
            OUT_VALID  <= 1'b1;
            ALU_OUT    <= w_res;
            Arith_flag <= w_arith;
            Logic_flag <= w_logic;
            CMP_flag   <= w_cmp;
            Shift_flag <= w_shift;
            Carry_flag <= w_carry;
            Div_err    <= w_err;
         end else if (w_load_div) begin
            OUT_VALID  <= 1'b1;
            ALU_OUT    <= w_quotient;
            Arith_flag <= 1'b1;
            Logic_flag <= 1'b0;
            CMP_flag   <= 1'b0;
            Shift_flag <= 1'b0;
            Carry_flag <= 1'b0;
            Div_err    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (vector table, corner sequences, random vs model)

module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  A, B;
   logic [3:0]    ALU_FUN;
   logic          OUT_VALID;
   logic [W-1:0]  ALU_OUT;
   logic          Arith_flag, Logic_flag, CMP_flag, Shift_flag, Carry_flag, Div_err;

   always #5 CLK = ~CLK;

   alu_seq #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .A          (A),
      .B          (B),
      .ALU_FUN    (ALU_FUN),
      .OUT_VALID  (OUT_VALID),
      .ALU_OUT    (ALU_OUT),
      .Arith_flag (Arith_flag),
      .Logic_flag (Logic_flag),
      .CMP_flag   (CMP_flag),
      .Shift_flag (Shift_flag),
      .Carry_flag (Carry_flag),
      .Div_err    (Div_err)
   );

   // flag vector order: {arith, logic, cmp, shift, carry, div_err}
   localparam logic [5:0] F_ARITH = 6'b100000;
   localparam logic [5:0] F_LOGIC = 6'b010000;
   localparam logic [5:0] F_CMP   = 6'b001000;
   localparam logic [5:0] F_SHIFT = 6'b000100;
   localparam logic [5:0] F_CARRY = 6'b000010;
   localparam logic [5:0] F_ERR   = 6'b000001;

   typedef struct {
      logic [3:0]   fun;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [5:0]   flags;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [5:0]   flags;
      int           lat;
   } exp_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic logic [5:0] flags_now();
      return {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Carry_flag, Div_err};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic add_vec(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] r, input logic [5:0] fl);
      vec_t v;
      v.fun = f; v.a = a; v.b = b; v.res = r; v.flags = fl;
      vecs.push_back(v);
   endtask

   // Reference model from the opcode rules, plain unsigned arithmetic
   function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint m  = (longint'(1) << W);
      int sh;
      e.res = '0; e.flags = '0; e.lat = 1;
      case (f)
         4'd0:  begin e.res = W'((ua + ub) % m); e.flags = F_ARITH | ((ua + ub >= m) ? F_CARRY : 6'b0); end
         4'd1:  begin e.res = W'((ua - ub + m) % m); e.flags = F_ARITH | ((ua < ub) ? F_CARRY : 6'b0); end
         4'd2:  begin e.res = W'((ua * ub) % m); e.flags = F_ARITH; end
         4'd3:  begin
                   if (ub == 0) begin e.res = W'(m - 1); e.flags = F_ARITH | F_ERR; end
                   else begin e.res = W'(ua / ub); e.flags = F_ARITH; e.lat = W + 1; end
                end
         4'd4:  begin e.res = a & b;    e.flags = F_LOGIC; end
         4'd5:  begin e.res = a | b;    e.flags = F_LOGIC; end
         4'd6:  begin e.res = ~(a & b); e.flags = F_LOGIC; end
         4'd7:  begin e.res = ~(a | b); e.flags = F_LOGIC; end
         4'd8:  begin e.res = a ^ b;    e.flags = F_LOGIC; end
         4'd9:  begin e.res = ~(a ^ b); e.flags = F_LOGIC; end
         4'd10: begin e.res = (ua == ub) ? W'(1) : W'(0); e.flags = F_CMP; end
         4'd11: begin e.res = (ua >  ub) ? W'(2) : W'(0); e.flags = F_CMP; end
         4'd12: begin e.res = (ua <  ub) ? W'(3) : W'(0); e.flags = F_CMP; end
         4'd13, 4'd14: begin
`ifdef ALU_BARREL_SHIFT_EN
                   sh = int'(ub % W);
`else
                   sh = 1;
`endif
                   if (f == 4'd13) e.res = W'(ua / (longint'(1) << sh));
                   else            e.res = W'((ua * (longint'(1) << sh)) % m);
                   e.flags = F_SHIFT;
                end
         default: ;
      endcase
      return e;
   endfunction

   // Issue one op from idle and wait (bounded) for its OUT_VALID pulse
   task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      exp_t e;
      int   lat;
      bit   got;
      e = model(f, a, b);
      chk({tag, " ready"}, IN_READY, 1);
      IN_VALID = 1'b1; ALU_FUN = f; A = a; B = b;
      step();
      IN_VALID = 1'b0;
      lat = 1; got = 0;
      while (lat <= W + 4) begin
         if (OUT_VALID) begin got = 1; break; end
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, e.lat);
      if (got) begin
         chk({tag, " result"}, ALU_OUT, e.res);
         chk({tag, " flags"}, flags_now(), e.flags);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] sll_exp, srl_exp, prev_out;
      int k, ready_low, unstable, pulses;
      logic [3:0] f;
      logic [W-1:0] ra, rb;

`ifdef ALU_BARREL_SHIFT_EN
      sll_exp = 16'h0010;
      srl_exp = 16'h1000;
`else
      sll_exp = 16'h0002;
      srl_exp = 16'h4000;
`endif
      add_vec(ALU_ADD,    16'hFFFF, 16'h0001, 16'h0000, F_ARITH | F_CARRY);
      add_vec(ALU_XOR,    16'h00FF, 16'h0F0F, 16'h0FF0, F_LOGIC);
      add_vec(ALU_CMP_GT, 16'd5,    16'd3,    16'd2,    F_CMP);
      add_vec(ALU_DIV,    16'd9,    16'd0,    16'hFFFF, F_ARITH | F_ERR);
      add_vec(ALU_SUB,    16'd3,    16'd5,    16'hFFFE, F_ARITH | F_CARRY);
      add_vec(ALU_SUB,    16'd5,    16'd3,    16'h0002, F_ARITH);
      add_vec(ALU_NOP,    16'h1234, 16'h5678, 16'h0000, 6'b0);
      add_vec(ALU_SLL,    16'h0001, 16'd4,    sll_exp,  F_SHIFT);
      add_vec(ALU_SRL,    16'h8000, 16'd3,    srl_exp,  F_SHIFT);
      add_vec(ALU_MUL,    16'h0100, 16'h0100, 16'h0000, F_ARITH);
      add_vec(ALU_MUL,    16'd300,  16'd7,    16'd2100, F_ARITH);
      add_vec(ALU_AND,    16'hF0F0, 16'hFF00, 16'hF000, F_LOGIC);
      add_vec(ALU_OR,     16'h0F00, 16'h00F0, 16'h0FF0, F_LOGIC);
      add_vec(ALU_NAND,   16'hFFFF, 16'h00FF, 16'hFF00, F_LOGIC);
      add_vec(ALU_NOR,    16'h0F00, 16'h00F0, 16'hF00F, F_LOGIC);
      add_vec(ALU_XNOR,   16'h00FF, 16'h0F0F, 16'hF00F, F_LOGIC);
      add_vec(ALU_CMP_EQ, 16'd7,    16'd7,    16'd1,    F_CMP);
      add_vec(ALU_CMP_LT, 16'd2,    16'd9,    16'd3,    F_CMP);
      add_vec(ALU_CMP_LT, 16'd9,    16'd2,    16'd0,    F_CMP);

      // ---- reset ----
      RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = ALU_NOP;
      repeat (3) step();
      RST = 1'b0;
      step();
      chk("reset ready",  IN_READY, 1);
      chk("reset valid",  OUT_VALID, 0);
      chk("reset result", ALU_OUT, 0);
      chk("reset flags",  flags_now(), 0);

      // ---- back-to-back table ----
      foreach (vecs[i]) begin
         IN_VALID = 1'b1; ALU_FUN = vecs[i].fun; A = vecs[i].a; B = vecs[i].b;
         step();
         chk($sformatf("vec%0d ready", i),  IN_READY, 1);
         chk($sformatf("vec%0d valid", i),  OUT_VALID, 1);
         chk($sformatf("vec%0d result", i), ALU_OUT, vecs[i].res);
         chk($sformatf("vec%0d flags", i),  flags_now(), vecs[i].flags);
      end
      IN_VALID = 1'b0;
      step();
      chk("table valid pulse ends", OUT_VALID, 0);

      // ---- divide 100/7 with IN_VALID held throughout ----
      prev_out = ALU_OUT;
      IN_VALID = 1'b1; ALU_FUN = ALU_DIV; A = 16'd100; B = 16'd7;
      step();
      ALU_FUN = ALU_ADD; A = 16'd1; B = 16'd1;
      k = 1; ready_low = 0; unstable = 0;
      while (k <= 40 && !OUT_VALID) begin
         if (!IN_READY) ready_low++;
         if (ALU_OUT !== prev_out) unstable++;
         step();
         k++;
      end
      chk("div latency",        k, 17);
      chk("div ready low",      ready_low, 16);
      chk("div held stable",    unstable, 0);
      chk("div result",         ALU_OUT, 14);
      chk("div flags",          flags_now(), F_ARITH);
      chk("div ready at done",  IN_READY, 1);
      step();
      IN_VALID = 1'b0;
      chk("held add valid",  OUT_VALID, 1);
      chk("held add result", ALU_OUT, 2);
      step();
      chk("held add pulse ends", OUT_VALID, 0);

      // ---- divide by zero stays idle ----
      run_op(ALU_DIV, 16'd9, 16'd0, "divzero");
      chk("divzero ready after", IN_READY, 1);

      // ---- reset 5 cycles into a divide ----
      IN_VALID = 1'b1; ALU_FUN = ALU_DIV; A = 16'd1000; B = 16'd3;
      step();
      IN_VALID = 1'b0;
      repeat (4) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
      chk("abort ready",  IN_READY, 1);
      chk("abort result", ALU_OUT, 0);
      chk("abort flags",  flags_now(), 0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (OUT_VALID) pulses++;
         step();
      end
      chk("abort no valid", pulses, 0);
      run_op(ALU_SUB, 16'd3, 16'd5, "post-abort sub");
      chk("post-abort sub value", ALU_OUT, 16'hFFFE);
      chk("post-abort sub carry", Carry_flag, 1);

      // ---- random ops against the model ----
      for (int i = 0; i < 150; i++) begin
         f  = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 20));
            default: rb = W'($urandom);
         endcase
         run_op(f, ra, rb, $sformatf("rand%0d op%0d", i, f));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
